// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures an asynchronous MonClk in Clk cycles, qualifies lock, flags faults.
// Latency: a MonClk rising edge is detected 2-3 Clk after it occurs; Period/PeriodVld follow one Clk later.
// Backpressure: none; PeriodVld is a free-running strobe. Optional min/max history: CLK_PERIOD_MONITOR_HIST_EN.
module clk_period_monitor #(
   parameter int CNT_W    = 16,
   parameter int PER_MIN  = 9,
   parameter int PER_MAX  = 11,
   parameter int LOCK_CNT = 4,
   parameter int TIMEOUT  = 1024
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   input  logic             MonClk,
   input  logic             Clear,
   output logic [CNT_W-1:0] Period,
   output logic             PeriodVld,
   output logic             Locked,
   output logic             Fault,
`ifdef CLK_PERIOD_MONITOR_HIST_EN
   output logic             Timeout,
   output logic [CNT_W-1:0] PerMinSeen,
   output logic [CNT_W-1:0] PerMaxSeen
`else
   output logic             Timeout
`endif
);

   localparam int RUN_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_ALL1 = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] PMIN_V   = CNT_W'(PER_MIN);
   localparam logic [CNT_W-1:0] PMAX_V   = CNT_W'(PER_MAX);
   localparam logic [CNT_W-1:0] TMO_V    = CNT_W'(TIMEOUT);
   localparam logic [RUN_W-1:0] LOCK_V   = RUN_W'(LOCK_CNT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2
   } state_t;

   state_t           state_q, state_d;

   logic             s1_q, s2_q, s3_q;
   logic             rise;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] idle_q, idle_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             vld_q, vld_d;
   logic             locked_q, locked_d;
   logic             fault_q, fault_d;
   logic             tmo_q, tmo_d;

   logic [CNT_W-1:0] per_meas;
   logic             in_win;
   logic             meas_rise;
   logic             bad_ev;
   logic             tmo_ev;

   // Two-flop synchronizer for MonClk plus one delay flop for edge detection
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= MonClk;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;

   // Counter holds cycles since the last edge minus one, so the period is
   // counter+1; a saturated counter reports all-ones, which lands out of window.
   assign per_meas  = (cnt_q == CNT_ALL1) ? CNT_ALL1 : cnt_q + CNT_W'(1);
   assign in_win    = (per_meas >= PMIN_V) && (per_meas <= PMAX_V);
   assign meas_rise = En && (state_q == ST_MEAS) && rise;
   assign bad_ev    = meas_rise && !in_win;

   // A rise arriving in the same cycle as the timeout count wins over the timeout
   assign tmo_ev = En && !rise &&
                   (((state_q == ST_ARM)  && (idle_q == TMO_V)) ||
                    ((state_q == ST_MEAS) && (cnt_q  == TMO_V)));

   // State register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: En low always returns to IDLE; timeouts fall back to ARM
   always_comb begin
      state_d = state_q;
      if (!En) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_ARM;
            ST_ARM:  if (rise) state_d = ST_MEAS;
            ST_MEAS: if (tmo_ev) state_d = ST_ARM;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output/datapath next values: counters, period strobe, lock and sticky flags
   always_comb begin
      cnt_d    = '0;
      idle_d   = '0;
      run_d    = '0;
      period_d = period_q;
      vld_d    = 1'b0;
      locked_d = 1'b0;
      if (En) begin
         case (state_q)
            ST_ARM: begin
               // first edge only starts the measurement, no strobe
               if (!rise && !tmo_ev) idle_d = idle_q + CNT_W'(1);
            end
            ST_MEAS: begin
               run_d = run_q;
               if (rise) begin
                  period_d = per_meas;
                  vld_d    = 1'b1;
                  if (in_win) run_d = (run_q == LOCK_V) ? run_q : run_q + RUN_W'(1);
                  else        run_d = '0;
               end else if (tmo_ev) begin
                  run_d = '0;
               end else begin
                  cnt_d = (cnt_q == CNT_ALL1) ? cnt_q : cnt_q + CNT_W'(1);
               end
               // lock follows one cycle after the run count reaches its target
               locked_d = (run_q == LOCK_V) && !bad_ev && !tmo_ev;
            end
            default: begin
               run_d = '0;
            end
         endcase
      end

      // new fault events beat a coincident Clear
      if (bad_ev || tmo_ev) fault_d = 1'b1;
      else if (Clear)       fault_d = 1'b0;
      else                  fault_d = fault_q;

      if (tmo_ev)      tmo_d = 1'b1;
      else if (Clear)  tmo_d = 1'b0;
      else             tmo_d = tmo_q;
   end

   // Datapath registers
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         cnt_q    <= '0;
         idle_q   <= '0;
         run_q    <= '0;
         period_q <= '0;
         vld_q    <= 1'b0;
         locked_q <= 1'b0;
         fault_q  <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idle_q   <= idle_d;
         run_q    <= run_d;
         period_q <= period_d;
         vld_q    <= vld_d;
         locked_q <= locked_d;
         fault_q  <= fault_d;
         tmo_q    <= tmo_d;
      end
   end

   assign Period    = period_q;
   assign PeriodVld = vld_q;
   assign Locked    = locked_q;
   assign Fault     = fault_q;
   assign Timeout   = tmo_q;

`ifdef CLK_PERIOD_MONITOR_HIST_EN
   logic [CNT_W-1:0] min_q, min_d;
   logic [CNT_W-1:0] max_q, max_d;

   // Clear restarts the history, then any period reported in the same cycle is folded in
   always_comb begin
      min_d = Clear ? CNT_ALL1 : min_q;
      max_d = Clear ? '0       : max_q;
      if (vld_d) begin
         if (period_d < min_d) min_d = period_d;
         if (period_d > max_d) max_d = period_d;
      end
   end

   // History registers; reset to the empty-history values
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         min_q <= CNT_ALL1;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign PerMinSeen = min_q;
   assign PerMaxSeen = max_q;
`endif

endmodule

// File: doc/clk_period_monitor.md
Name: clk_period_monitor

Overview:
- Receiving end of a generated clock: measures an incoming, asynchronous clock (codec MCLK/BCLK/LRCK or a bench-generated clock) in units of the system clock `Clk`.
- Reports each measured period, qualifies lock against a tolerance window, and flags faults.
- Sits beside the WM8731 codec controller. The controller uses `Locked` to gate serial-audio traffic. The bench uses `Fault` to catch clock regressions.

Parameters:
- CNT_W, 16: width of the period counter and of `Period`.
- PER_MIN, 9: smallest acceptable period, in Clk cycles (inclusive).
- PER_MAX, 11: largest acceptable period, in Clk cycles (inclusive).
- LOCK_CNT, 4: consecutive in-window periods required to assert `Locked`.
- TIMEOUT, 1024: Clk cycles without a detected MonClk rising edge before a timeout fault. Must be less than 2^CNT_W − 1.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  asynchronous, active-high reset.
- En  in  1  monitor enable; deassertion returns the block to IDLE.
- MonClk  in  1  monitored clock; asynchronous to Clk.
- Clear  in  1  synchronous one-cycle clear of `Fault` and `Timeout`.
- Period  out  CNT_W  last measured period, in Clk cycles.
- PeriodVld  out  1  one-cycle strobe when `Period` updates.
- Locked  out  1  high after LOCK_CNT consecutive in-window periods.
- Fault  out  1  sticky: out-of-window period or timeout seen.
- Timeout  out  1  sticky: no MonClk edge within TIMEOUT cycles.

Behaviour:
- Reset (async, Rst=1) sets all outputs to 0, the synchronizer flops to 0, the counter to 0, the good-period run count to 0, and the state to IDLE.

Edge detection:
- MonClk passes through a 2-flop synchronizer s1→s2, then a delay flop s3.
- rise = s2 & ~s3. Detection latency is 2–3 Clk cycles after the true MonClk edge.

States:
- IDLE:
  - Counter = 0, run count = 0, `Locked` = 0.
  - En=1 → ARM.
- ARM:
  - Counter held at 0; waits for the first rise.
  - rise → MEASURE with counter = 0. No `PeriodVld` is issued for the first edge.
  - The timeout counter runs in ARM as well.
- MEASURE:
  - Counter increments each cycle and saturates at all-ones.
  - On rise: `Period` ← counter + 1, `PeriodVld` = 1 for one cycle, counter ← 0.
  - If PER_MIN ≤ counter+1 ≤ PER_MAX: run count increments, saturating at LOCK_CNT.
  - Otherwise: run count ← 0, `Locked` ← 0, `Fault` ← 1.
  - `Locked` ← 1 in the cycle after run count reaches LOCK_CNT.
- Timeout, in ARM or MEASURE:
  - Condition: counter (or the ARM idle count) reaches TIMEOUT with no rise.
  - Action: `Timeout` ← 1, `Fault` ← 1, `Locked` ← 0, run count ← 0, state ← ARM, counter ← 0.
- En=0 in any state → IDLE on the next cycle.
  - `Period`, `Fault` and `Timeout` retain their values.
  - `Locked` ← 0.
- `Clear`:
  - Clears `Fault` and `Timeout`.
  - If Clear=1 coincides with a new fault event in the same cycle, the fault event wins and the flag stays 1.
- Counter+1 arithmetic is done in CNT_W bits with saturation: a saturated counter reports all-ones, which is out of window.
- A rise detected in the same cycle that the timeout count is reached is treated as a rise; no timeout is flagged.
- Rst asserted mid-measurement aborts it immediately. No `PeriodVld` follows.

Optional Feature:
- Macro: CLK_PERIOD_MONITOR_HIST_EN.
- When defined, two extra outputs are present: PerMinSeen (out, CNT_W) and PerMaxSeen (out, CNT_W).
  - Each `PeriodVld` updates PerMinSeen = min(PerMinSeen, Period) and PerMaxSeen = max(PerMaxSeen, Period).
  - Reset or `Clear` loads PerMinSeen = all-ones and PerMaxSeen = 0.
- When undefined, the ports and registers are absent and all other behaviour is identical.

Test Plan:
- Lock: Clk period 20 ns, MonClk period 200 ns, En=1 → `PeriodVld` strobes with `Period`=10; `Locked`=1 after the 4th in-window period; `Fault`=0.
- Out of window: MonClk period changed to 300 ns after lock → next `Period`=15, `Fault`=1, `Locked`=0; after 4 periods at 200 ns, `Locked` re-asserts and `Fault` stays 1 until `Clear`.
- Timeout: MonClk stopped high while locked → after 1024 cycles `Timeout`=1, `Fault`=1, `Locked`=0; restarting MonClk gives no strobe on the first edge, then `Period`=10.
- Clear vs fault: pulse `Clear` in the same cycle as an out-of-window strobe → `Fault` remains 1; a `Clear` pulse in a quiet cycle → `Fault`=0, `Timeout`=0.
- En/reset: En=0 mid-period → `Locked`=0 the next cycle with `Period` held. Rst asserted mid-period → all outputs 0 asynchronously and no strobe afterwards until two new edges arrive.
- HIST (macro defined): periods 10, 9, 11, 10 → PerMinSeen=9, PerMaxSeen=11; `Clear` → PerMinSeen=0xFFFF, PerMaxSeen=0.
